// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: stereo I2S / left-justified DAC serial transmitter with a frame FIFO.
// Ports:
//   clk_clk, reset_reset_n      system clock (>= 4x BCLK), asynchronous active-low reset
//   enable, mute                transmitter enable; mute forces DACDAT low while the FIFO keeps draining
//   sink_data/valid/ready       stereo frame sink, {left, right}, two's complement
//   audio_BCLK, audio_DACLRCK   codec-mastered bit and LR clocks (asynchronous)
//   audio_DACDAT                serial data to the codec
//   fifo_level                  frames currently buffered
//   underrun_count/clear        saturating count of frames sent as silence for lack of data
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int FORMAT     = 0,
    parameter int SLOT_BITS  = 32
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          enable,
    input  logic                          mute,
    input  logic [2*DATA_WIDTH-1:0]       sink_data,
    input  logic                          sink_valid,
    output logic                          sink_ready,
    input  logic                          audio_BCLK,
    input  logic                          audio_DACLRCK,
    output logic                          audio_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_count,
    input  logic                          underrun_clear
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(SLOT_BITS);
    localparam int OFF = (FORMAT == 0) ? 1 : 0;
    localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_BITS - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              bclk_sync, lrck_sync;
    logic                    bclk_fall, lr_fall, lr_rise, left_edge, right_edge;
    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0] head;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    ready_en, enable_d, full, empty, push, pop, flush;
    logic                    load, underrun, restart, dacdat_nxt;
    logic [CW-1:0]           bit_cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]   left_r, right_r, ld_left, ld_right, cur_sample, shifted;
    logic [31:0]             k;

    // [0],[1] synchronise; [2] holds the previous synchronised value for edge detection
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], audio_BCLK};
            lrck_sync <= {lrck_sync[1:0], audio_DACLRCK};
        end
    end

    assign bclk_fall  = bclk_sync[2] & ~bclk_sync[1];
    assign lr_fall    = lrck_sync[2] & ~lrck_sync[1];
    assign lr_rise    = ~lrck_sync[2] & lrck_sync[1];
    assign left_edge  = bclk_fall & ((FORMAT == 0) ? lr_fall : lr_rise);
    assign right_edge = bclk_fall & ((FORMAT == 0) ? lr_rise : lr_fall);

    assign full       = fifo_level == FULL_LVL;
    assign empty      = fifo_level == '0;
    assign sink_ready = ready_en & ~full;
    assign push       = sink_valid & sink_ready;
    assign flush      = enable_d & ~enable;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr] <= sink_data;
    end

    // a push landing in the flush cycle is discarded so the level is empty right after disable
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ready_en   <= 1'b0;
            enable_d   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            enable_d <= enable;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                fifo_level <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = !enable ? IDLE :
                    left_edge ? LEFT :
                    (right_edge && state == LEFT) ? RIGHT : state;
    end

    // the bit for the new count is computed here so DACDAT lands on the same edge as the count
    always_comb begin
        load       = enable & left_edge;
        pop        = load & ~empty;
        underrun   = load & empty;
        restart    = load | (enable & right_edge & (state == LEFT));
        cnt_nxt    = restart ? '0 : (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
        ld_left    = empty ? '0 : head[2*DATA_WIDTH-1:DATA_WIDTH];
        ld_right   = empty ? '0 : head[DATA_WIDTH-1:0];
        cur_sample = load ? ld_left : (state_nxt == RIGHT) ? right_r : left_r;
        k          = 32'(cnt_nxt) - 32'(OFF);
        shifted    = cur_sample >> (32'(DATA_WIDTH - 1) - k);
        dacdat_nxt = !enable ? 1'b0 :
                     !bclk_fall ? audio_DACDAT :
                     (state_nxt == IDLE || mute || k >= 32'(DATA_WIDTH)) ? 1'b0 : shifted[0];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            audio_DACDAT   <= 1'b0;
            bit_cnt        <= '0;
            left_r         <= '0;
            right_r        <= '0;
            underrun_count <= '0;
        end else begin
            audio_DACDAT <= dacdat_nxt;
            if (bclk_fall && state_nxt != IDLE) bit_cnt <= cnt_nxt;
            if (load) begin
                left_r  <= ld_left;
                right_r <= ld_right;
            end
            underrun_count <= underrun_clear ? '0 :
                              (underrun && underrun_count != 16'hFFFF) ? underrun_count + 16'd1 :
                              underrun_count;
        end
    end
endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Parametrised audio DAC serial transmitter with an internal sample FIFO; successor to the fixed stereo DAC output path of the soc_system audio core.
- Accepts stereo frames over a valid/ready sink and serialises them onto the codec's DACDAT pin.
- BCLK and DACLRCK are generated by the codec (codec master) and sampled in the system clock domain.
- Adds selectable I2S or left-justified format, configurable sample width and FIFO depth, mute, underrun detection and counting, and FIFO level reporting.

Parameters:
- DATA_WIDTH, 24, bits per channel sample (8..32).
- FIFO_DEPTH, 16, stereo frames buffered; power of two, >= 2.
- FORMAT, 0, serial format: 0 = I2S (MSB one BCLK after the LRCK edge), 1 = left-justified (MSB on the LRCK edge).
- SLOT_BITS, 32, BCLK periods per channel slot; must be >= DATA_WIDTH + 1 when FORMAT = 0, and >= DATA_WIDTH when FORMAT = 1.

Ports:
- clk_clk  in  1  system clock; must be at least 4x the BCLK frequency.
- reset_reset_n  in  1  asynchronous active-low reset.
- enable  in  1  transmitter enable.
- mute  in  1  forces DACDAT to 0; FIFO still drains.
- sink_data  in  2*DATA_WIDTH  frame data: [2*DATA_WIDTH-1:DATA_WIDTH] = left, [DATA_WIDTH-1:0] = right, two's complement.
- sink_valid  in  1  frame valid.
- sink_ready  out  1  FIFO can accept a frame.
- audio_BCLK  in  1  codec bit clock (asynchronous).
- audio_DACLRCK  in  1  codec LR clock (asynchronous).
- audio_DACDAT  out  1  serial data to codec.
- fifo_level  out  clog2(FIFO_DEPTH)+1  frames currently stored.
- underrun_count  out  16  saturating count of underrun frames.
- underrun_clear  in  1  synchronous clear of underrun_count.

Behaviour:
- Reset values: audio_DACDAT 0, sink_ready 0 for the reset cycle then 1, fifo_level 0, underrun_count 0, FSM in IDLE, FIFO empty.
- Synchronisation:
  - audio_BCLK and audio_DACLRCK each pass through a 2-FF synchroniser, followed by a third register for edge detection.
  - bclk_fall is a one-cycle pulse on a synchronised BCLK 1->0 transition.
  - A left-start edge is a DACLRCK 1->0 transition for I2S, or a 0->1 transition for left-justified. The opposite transition is the right-start edge.
  - LRCK edges are acted on only in a cycle where bclk_fall is also asserted.
- FIFO:
  - Push when sink_valid && sink_ready.
  - sink_ready = !full; it does not look ahead at a same-cycle pop.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: DACDAT = 0. Leaves on a left-start edge while enable = 1.
  - LEFT, RIGHT: serialising.
- On each left-start edge (from IDLE, RIGHT or LEFT):
  - If the FIFO is non-empty: pop one frame and load the left and right shift registers.
  - If the FIFO is empty: underrun. Load zeros and increment underrun_count, saturating at 16'hFFFF.
  - Clear bit_cnt and go to LEFT.
- On a right-start edge in LEFT: clear bit_cnt and go to RIGHT.
- A right-start edge seen in IDLE is ignored.
- Bit timing:
  - bit_cnt increments on every bclk_fall after the edge.
  - DACDAT is updated only on bclk_fall (or on the edge cycle itself).
  - Bit index k = bit_cnt - (FORMAT==0 ? 1 : 0). 0 <= k < DATA_WIDTH drives sample[DATA_WIDTH-1-k]; any other k drives 0.
  - bit_cnt saturates at SLOT_BITS-1.
- Latency: DACDAT changes exactly 3 clk_clk cycles after a BCLK falling edge at the pin (2 synchroniser cycles + 1 output register).
- Mute: output is 0 while mute = 1. Pops and underrun accounting still happen. Mute is sampled on each bclk_fall.
- Disable: enable 1->0 forces DACDAT to 0 on the next cycle, flushes the FIFO (fifo_level = 0 the next cycle), and returns the FSM to IDLE. Frames pushed while enable = 0 are accepted and stored. After re-enable, output waits for the next left-start edge.
- underrun_clear has priority over a simultaneous increment; the result is 0.
- Asynchronous reset mid-frame immediately returns every output and internal state to its reset value.

Test Plan:
- I2S, DATA_WIDTH = 24, SLOT_BITS = 32, BCLK = clk/8. Push frame L = 24'h800001, R = 24'h7FFFFE -> after the left-start edge: DACDAT = 0 for one BCLK, then bits 1,0..0,1 MSB-first (24 bits), then 0 until the right edge; the right slot mirrors this with the R bits; each DACDAT change occurs 3 clk after the BCLK fall.
- FORMAT = 1, same data -> MSB appears in the same BCLK period as the LRCK 0->1 edge; left is sent while LRCK is high.
- Push FIFO_DEPTH frames with no BCLK running -> sink_ready = 0 and fifo_level = 16. A further sink_valid is not accepted. After one left-start edge, fifo_level = 15 and sink_ready = 1.
- Empty FIFO for 3 frames -> DACDAT stays 0 and underrun_count = 3. Pulse underrun_clear together with a 4th underrun -> underrun_count = 0.
- mute = 1 with 4 frames queued -> DACDAT stays 0 and fifo_level decrements once per frame. Deassert mute mid-slot -> output resumes at the next bclk_fall with the correct bit index.
- Deassert reset_reset_n mid-left-slot -> DACDAT = 0 and fifo_level = 0 asynchronously. After release, no output until the next left-start edge.
